// File: rtl/crash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : crash_arbiter
// Description : Pixel-stream collision arbiter for enemy hits, player crashes
//               and the bomb inventory; registered pulses on the VGA clock.
// Revision    : 1.0 - initial release
// ============================================================================
module crash_arbiter #(
    parameter int ENEMY_NUM     = 8,
    parameter int ENEMY_IDX_W   = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int INVULN_CNT_W  = 6,
    parameter int BOMB_INIT     = 1,
    parameter int BOMB_MAX      = 3,
    parameter int BOMB_W        = 2
) (
    input  logic                   clk_vga,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   v_sync_i,
    input  logic                   me_alpha_i,
    input  logic                   bullet_alpha_i,
    input  logic                   enemy_alpha_i,
    input  logic [ENEMY_IDX_W-1:0] enemy_idx_i,
    input  logic                   bomb_req_i,
    input  logic                   bomb_add_i,
    output logic                   crash_enemy_bullet_o,
    output logic                   crash_me_enemy_o,
    output logic [ENEMY_IDX_W-1:0] crash_idx_o,
    output logic                   me_hit_o,
    output logic                   invuln_o,
    output logic                   bomb_o,
    output logic [BOMB_W-1:0]      bomb_cnt_o
);

    typedef enum logic [0:0] {
        ST_ARMED  = 1'b0,
        ST_INVULN = 1'b1
    } state_t;

    localparam logic [INVULN_CNT_W-1:0] c_invuln_load = INVULN_CNT_W'(INVULN_FRAMES);
    localparam logic [INVULN_CNT_W-1:0] c_invuln_last = INVULN_CNT_W'(1);
    localparam logic [BOMB_W-1:0]       c_bomb_init   = BOMB_W'(BOMB_INIT);
    localparam logic [BOMB_W-1:0]       c_bomb_max    = BOMB_W'(BOMB_MAX);
    localparam logic [BOMB_W-1:0]       c_bomb_one    = BOMB_W'(1);
    localparam logic [ENEMY_NUM-1:0]    c_slot_one    = ENEMY_NUM'(1);

    logic                    r_vsync_d;
    logic [ENEMY_NUM-1:0]    r_mask;
    state_t                  r_state;
    logic [INVULN_CNT_W-1:0] r_invuln_cnt;
    logic                    r_bomb_lock;
    logic [BOMB_W-1:0]       r_bomb_cnt;

    logic                    w_frame_start;
    logic [ENEMY_NUM-1:0]    w_mask_eff;
    logic [ENEMY_NUM-1:0]    w_mask_nxt;
    logic                    w_bullet_hit;
    logic                    w_me_crash;
    state_t                  w_state_nxt;
    logic [INVULN_CNT_W-1:0] w_invuln_cnt_nxt;
    logic                    w_lock_eff;
    logic                    w_fire;
    logic                    w_lock_nxt;
    logic [BOMB_W-1:0]       w_bomb_cnt_nxt;

    // Frame-start clears are applied before this cycle's hit/fire decisions.
    always_comb begin
        w_frame_start    = v_sync_i & ~r_vsync_d;
        w_mask_eff       = w_frame_start ? '0 : r_mask;
        w_bullet_hit     = en_i & bullet_alpha_i & enemy_alpha_i & ~w_mask_eff[enemy_idx_i];
        w_mask_nxt       = w_mask_eff;
        if (w_bullet_hit) begin
            w_mask_nxt = w_mask_eff | (c_slot_one << enemy_idx_i);
        end

        w_me_crash       = 1'b0;
        w_state_nxt      = r_state;
        w_invuln_cnt_nxt = r_invuln_cnt;
        case (r_state)
            ST_ARMED: begin
                w_me_crash = en_i & me_alpha_i & enemy_alpha_i;
                if (w_me_crash) begin
                    w_state_nxt      = ST_INVULN;
                    w_invuln_cnt_nxt = c_invuln_load;
                end
            end
            ST_INVULN: begin
                if (w_frame_start) begin
                    if (r_invuln_cnt == c_invuln_last) begin
                        w_state_nxt = ST_ARMED;
                    end
                    w_invuln_cnt_nxt = r_invuln_cnt - c_invuln_last;
                end
            end
            default: w_state_nxt = ST_ARMED;
        endcase

        w_lock_eff     = w_frame_start ? 1'b0 : r_bomb_lock;
        w_fire         = en_i & bomb_req_i & (r_bomb_cnt != '0) & ~w_lock_eff;
        w_lock_nxt     = w_lock_eff | w_fire;
        w_bomb_cnt_nxt = r_bomb_cnt;
        // Fire together with a pickup leaves the count unchanged.
        if (bomb_add_i && !w_fire) begin
            if (r_bomb_cnt != c_bomb_max) begin
                w_bomb_cnt_nxt = r_bomb_cnt + c_bomb_one;
            end
        end else if (w_fire && !bomb_add_i) begin
            w_bomb_cnt_nxt = r_bomb_cnt - c_bomb_one;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_vsync_d            <= 1'b0;
            r_mask               <= '0;
            r_state              <= ST_ARMED;
            r_invuln_cnt         <= '0;
            r_bomb_lock          <= 1'b0;
            r_bomb_cnt           <= c_bomb_init;
            crash_enemy_bullet_o <= 1'b0;
            crash_me_enemy_o     <= 1'b0;
            me_hit_o             <= 1'b0;
            crash_idx_o          <= '0;
            bomb_o               <= 1'b0;
        end else begin
            r_vsync_d            <= v_sync_i;
            r_mask               <= w_mask_nxt;
            r_state              <= w_state_nxt;
            r_invuln_cnt         <= w_invuln_cnt_nxt;
            r_bomb_lock          <= w_lock_nxt;
            r_bomb_cnt           <= w_bomb_cnt_nxt;
            crash_enemy_bullet_o <= w_bullet_hit;
            crash_me_enemy_o     <= w_me_crash;
            me_hit_o             <= w_me_crash;
            bomb_o               <= w_fire;
            if (w_bullet_hit || w_me_crash) begin
                crash_idx_o <= enemy_idx_i;
            end
        end
    end

    assign invuln_o   = (r_state == ST_INVULN);
    assign bomb_cnt_o = r_bomb_cnt;

endmodule
`default_nettype wire

// File: tb/tb_crash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_crash_arbiter
// Description : Self-checking bench for crash_arbiter: vector table, scoreboard
//               against a cycle model, and directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crash_arbiter;

    logic       clk_vga = 1'b0;
    logic       rst = 1'b1;
    logic       en_i = 1'b0, v_sync_i = 1'b0, me_alpha_i = 1'b0;
    logic       bullet_alpha_i = 1'b0, enemy_alpha_i = 1'b0;
    logic [2:0] enemy_idx_i = 3'd0;
    logic       bomb_req_i = 1'b0, bomb_add_i = 1'b0;
    logic       crash_enemy_bullet_o, crash_me_enemy_o, me_hit_o, invuln_o, bomb_o;
    logic [2:0] crash_idx_o;
    logic [1:0] bomb_cnt_o;

    crash_arbiter dut (
        .clk_vga              (clk_vga),
        .rst                  (rst),
        .en_i                 (en_i),
        .v_sync_i             (v_sync_i),
        .me_alpha_i           (me_alpha_i),
        .bullet_alpha_i       (bullet_alpha_i),
        .enemy_alpha_i        (enemy_alpha_i),
        .enemy_idx_i          (enemy_idx_i),
        .bomb_req_i           (bomb_req_i),
        .bomb_add_i           (bomb_add_i),
        .crash_enemy_bullet_o (crash_enemy_bullet_o),
        .crash_me_enemy_o     (crash_me_enemy_o),
        .crash_idx_o          (crash_idx_o),
        .me_hit_o             (me_hit_o),
        .invuln_o             (invuln_o),
        .bomb_o               (bomb_o),
        .bomb_cnt_o           (bomb_cnt_o)
    );

    always #5 clk_vga = ~clk_vga;

    // {bullet, crash_me, me_hit, idx, invuln, bomb, cnt}
    typedef logic [9:0] out_t;
    out_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_eb = 0, n_mc = 0, n_bomb = 0;
    logic [2:0] hit_idx[$];

    // Reference model state
    logic       m_vs_d;
    logic [7:0] m_mask;
    logic       m_inv;
    int         m_cnt;
    logic       m_lock;
    int         m_bomb;
    logic [2:0] m_idx;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic out_t dut_out();
        return {crash_enemy_bullet_o, crash_me_enemy_o, me_hit_o, crash_idx_o,
                invuln_o, bomb_o, bomb_cnt_o};
    endfunction

    task automatic model_reset();
        m_vs_d = 1'b0; m_mask = 8'h00; m_inv = 1'b0; m_cnt = 0;
        m_lock = 1'b0; m_bomb = 1; m_idx = 3'd0;
    endtask

    task automatic finish_cycle();
        out_t e;
        @(posedge clk_vga);
        #1;
        e = sb.pop_front();
        check("cycle", {6'd0, dut_out()}, {6'd0, e});
        if (crash_enemy_bullet_o) begin n_eb++; hit_idx.push_back(crash_idx_o); end
        if (crash_me_enemy_o) n_mc++;
        if (bomb_o) n_bomb++;
    endtask

    task automatic cyc(input logic en, input logic vs, input logic me, input logic bul,
                       input logic ea, input logic [2:0] idx, input logic req, input logic add);
        logic fs, hit, mc, fire, lk;
        logic [7:0] mk;
        en_i = en; v_sync_i = vs; me_alpha_i = me; bullet_alpha_i = bul;
        enemy_alpha_i = ea; enemy_idx_i = idx; bomb_req_i = req; bomb_add_i = add;
        fs  = vs & ~m_vs_d;
        mk  = fs ? 8'h00 : m_mask;
        hit = en & bul & ea & ~mk[idx];
        if (hit) mk[idx] = 1'b1;
        m_mask = mk;
        m_vs_d = vs;
        mc = en & me & ea & ~m_inv;
        if (hit | mc) m_idx = idx;
        if (mc) begin
            m_inv = 1'b1; m_cnt = 60;
        end else if (m_inv && fs) begin
            if (m_cnt == 1) m_inv = 1'b0;
            m_cnt = m_cnt - 1;
        end
        lk   = fs ? 1'b0 : m_lock;
        fire = en & req & (m_bomb > 0) & ~lk;
        m_lock = lk | fire;
        if (add && !fire) begin
            if (m_bomb < 3) m_bomb++;
        end else if (fire && !add) begin
            m_bomb--;
        end
        sb.push_back({hit, mc, mc, m_idx, m_inv, fire, 2'(m_bomb)});
        finish_cycle();
    endtask

    task automatic idle(input logic vs);
        cyc(1'b1, vs, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic ov);
        rst = 1'b1;
        en_i = 1'b1; v_sync_i = ov; me_alpha_i = ov; bullet_alpha_i = ov;
        enemy_alpha_i = ov; enemy_idx_i = 3'd6; bomb_req_i = ov; bomb_add_i = ov;
        model_reset();
        sb.push_back({3'b000, 3'd0, 1'b0, 1'b0, 2'd1});
        finish_cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       en, vs, me, bul, ea;
        logic [2:0] idx;
        logic       req, add;
        logic       eb, mc;
        logic [2:0] xidx;
        logic       inv, bomb;
        logic [1:0] cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0, 1'b0,1'b0,3'd0,1'b0,1'b0,2'd1};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,3'd5,1'b0,1'b0, 1'b1,1'b0,3'd5,1'b0,1'b0,2'd1};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,3'd5,1'b0,1'b0, 1'b0,1'b0,3'd5,1'b0,1'b0,2'd1};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,3'd2,1'b0,1'b0, 1'b1,1'b0,3'd2,1'b0,1'b0,2'd1};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,3'd2,1'b0,1'b0, 1'b1,1'b0,3'd2,1'b0,1'b0,2'd1};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,3'd2,1'b0,1'b0, 1'b0,1'b0,3'd2,1'b0,1'b0,2'd1};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b1, 1'b0,1'b0,3'd2,1'b0,1'b0,2'd2};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,1'b1, 1'b0,1'b0,3'd2,1'b0,1'b1,2'd2};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,1'b1, 1'b0,1'b0,3'd2,1'b0,1'b0,2'd3};
        tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,1'b0, 1'b0,1'b0,3'd2,1'b0,1'b0,2'd3};
        tbl[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,1'b1,1'b0, 1'b0,1'b0,3'd2,1'b0,1'b1,2'd2};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b1,3'd4,1'b0,1'b0, 1'b0,1'b1,3'd4,1'b1,1'b0,2'd3 - 2'd1};

        model_reset();
        repeat (2) @(posedge clk_vga);
        #1;
        do_reset(1'b0);
        check("reset_state", {6'd0, dut_out()}, {6'd0, 10'b000_000_0_0_01});

        // Vector table
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].en, tbl[i].vs, tbl[i].me, tbl[i].bul, tbl[i].ea, tbl[i].idx,
                tbl[i].req, tbl[i].add);
            check($sformatf("tbl%0d", i), {6'd0, dut_out()},
                  {6'd0, tbl[i].eb, tbl[i].mc, tbl[i].mc, tbl[i].xidx, tbl[i].inv,
                   tbl[i].bomb, tbl[i].cnt});
        end

        // One bullet hit per enemy per frame
        do_reset(1'b0);
        n_eb = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        check("first_hit_latency", {15'd0, crash_enemy_bullet_o}, 16'd1);
        check("first_hit_idx", {13'd0, crash_idx_o}, 16'd5);
        repeat (19) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        check("hits_frame1", 16'(n_eb), 16'd1);
        idle(1'b1);
        idle(1'b0);
        repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        check("hits_frame2", 16'(n_eb), 16'd2);

        // Alternating slots within one frame
        n_eb = 0;
        hit_idx.delete();
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 3'd2 : 3'd3, 1'b0, 1'b0);
        check("alt_hits", 16'(n_eb), 16'd2);
        if (hit_idx.size() == 2) begin
            check("alt_idx0", {13'd0, hit_idx[0]}, 16'd2);
            check("alt_idx1", {13'd0, hit_idx[1]}, 16'd3);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        check("hit_on_frame_start", {15'd0, crash_enemy_bullet_o}, 16'd1);

        // Player crash and invulnerability window
        idle(1'b0);
        n_mc = 0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        check("me_crash", {13'd0, crash_me_enemy_o, me_hit_o, invuln_o}, 16'b111);
        check("me_crash_idx", {13'd0, crash_idx_o}, 16'd4);
        for (int f = 1; f <= 59; f++) begin
            repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
            repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        end
        check("still_invuln_59", {15'd0, invuln_o}, 16'd1);
        check("no_crash_in_window", 16'(n_mc), 16'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        check("invuln_drop_60", {14'd0, invuln_o, crash_me_enemy_o}, 16'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        check("crash_after_window", {14'd0, crash_me_enemy_o, invuln_o}, 16'b11);

        // Held bomb button, then saturating pickups
        do_reset(1'b0);
        n_bomb = 0;
        for (int f = 0; f < 3; f++) begin
            repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
            repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        end
        check("held_bomb_pulses", 16'(n_bomb), 16'd1);
        check("bomb_cnt_empty", {14'd0, bomb_cnt_o}, 16'd0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        check("bomb_cnt_sat", {14'd0, bomb_cnt_o}, 16'd3);

        // Reset while invulnerable with no bombs left
        do_reset(1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
        check("pre_rst_state", {13'd0, invuln_o, bomb_cnt_o}, 16'b100);
        do_reset(1'b1);
        check("rst_midframe", {6'd0, dut_out()}, {6'd0, 10'b000_000_0_0_01});
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
        check("crash_after_rst", {12'd0, crash_me_enemy_o, crash_idx_o}, {12'd0, 1'b1, 3'd7});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
